// File: rtl/conway_pkg.sv
// Board geometry shared by the seeder, life engine and VGA renderer, plus the seeder FSM states.
package conway_pkg;

   localparam int BOARD_WIDTH_DEF  = 32;
   localparam int BOARD_HEIGHT_DEF = 16;
   localparam int DENSITY_BITS_DEF = 3;

   localparam int CELLS  = BOARD_WIDTH_DEF * BOARD_HEIGHT_DEF;
   localparam int ADDR_W = $clog2(CELLS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GATHER,
      ST_WRITE,
      ST_FINISH
   } seeder_state_t;

endpackage

// File: rtl/seeder_sampler.sv
// Collects DENSITY_BITS serial random bits per cell (first bit lands in the MSB) and
// compares the completed sample against the alive threshold.
module seeder_sampler
   import conway_pkg::*;
#(
   parameter int DENSITY_BITS = DENSITY_BITS_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    shift,
   input  logic                    random_bit,
   input  logic [DENSITY_BITS-1:0] threshold,
   output logic                    sample_done,
   output logic                    alive
);

   localparam int CNT_W = $clog2(DENSITY_BITS + 1);

   logic [DENSITY_BITS-1:0] sample;
   logic [DENSITY_BITS-1:0] sample_next;
   logic [CNT_W-1:0]        bit_cnt;

   assign sample_next = {sample[DENSITY_BITS-2:0], random_bit};

   always_ff @(posedge clk) begin
      if (reset) begin
         sample  <= '0;
         bit_cnt <= '0;
      end else if (clear) begin
         bit_cnt <= '0;
      end else if (shift) begin
         sample  <= sample_next;
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   // Decision is taken on the cycle the last bit arrives, so compare the value about to be stored.
   assign sample_done = shift && (bit_cnt == CNT_W'(DENSITY_BITS - 1));
   assign alive       = (sample_next < threshold);

endmodule

// File: rtl/conway_board_seeder.sv
// Fills the board RAM with a random pattern: DENSITY_BITS LFSR bits per cell, alive iff sample < density.
// One cell per DENSITY_BITS+1 cycles when the RAM never stalls; wr_ready low holds the write indefinitely.
module conway_board_seeder
   import conway_pkg::*;
#(
   parameter int BOARD_WIDTH  = BOARD_WIDTH_DEF,
   parameter int BOARD_HEIGHT = BOARD_HEIGHT_DEF,
   parameter int DENSITY_BITS = DENSITY_BITS_DEF
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        start,
   input  logic [DENSITY_BITS-1:0]                     density,
   input  logic                                        random_bit,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        wr_valid,
   input  logic                                        wr_ready,
   output logic [$clog2(BOARD_WIDTH*BOARD_HEIGHT)-1:0] wr_addr,
   output logic                                        wr_data
);

   localparam int NUM_CELLS = BOARD_WIDTH * BOARD_HEIGHT;
   localparam int AW        = $clog2(NUM_CELLS);

   seeder_state_t           state;
   logic [AW-1:0]           cell_cnt;
   logic [DENSITY_BITS-1:0] density_q;
   logic                    sample_done;
   logic                    alive;
   logic                    last_cell;
   logic                    sampler_clear;

   assign last_cell     = (cell_cnt == AW'(NUM_CELLS - 1));
   assign sampler_clear = ((state == ST_IDLE) && start) || ((state == ST_WRITE) && wr_ready);

   seeder_sampler #(
      .DENSITY_BITS (DENSITY_BITS)
   ) u_sampler (
      .clk         (clk),
      .reset       (reset),
      .clear       (sampler_clear),
      .shift       (state == ST_GATHER),
      .random_bit  (random_bit),
      .threshold   (density_q),
      .sample_done (sample_done),
      .alive       (alive)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 1'b0;
         cell_cnt  <= '0;
         density_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  density_q <= density;
                  cell_cnt  <= '0;
                  busy      <= 1'b1;
                  state     <= ST_GATHER;
               end
            end
            ST_GATHER: begin
               if (sample_done) begin
                  wr_data  <= alive;
                  wr_addr  <= cell_cnt;
                  wr_valid <= 1'b1;
                  state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (wr_ready) begin
                  wr_valid <= 1'b0;
                  // Counter stops at the last cell so no write can ever be issued past it.
                  if (last_cell) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_FINISH;
                  end else begin
                     cell_cnt <= cell_cnt + AW'(1);
                     state    <= ST_GATHER;
                  end
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conway_board_seeder.sv
// Drives a known per-cell sample stream (junk bits whenever nothing should be sampled) and
// checks every board write against sample < latched density.
module tb_conway_board_seeder;

   localparam int W     = 32;
   localparam int H     = 16;
   localparam int DB    = 3;
   localparam int NCELL = W * H;
   localparam int AW    = $clog2(NCELL);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [DB-1:0] density = '0;
   logic          random_bit = 1'b0;
   logic          busy;
   logic          done;
   logic          wr_valid;
   logic          wr_ready = 1'b1;
   logic [AW-1:0] wr_addr;
   logic          wr_data;

   int checks = 0;
   int errors = 0;

   conway_board_seeder #(
      .BOARD_WIDTH  (W),
      .BOARD_HEIGHT (H),
      .DENSITY_BITS (DB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .density    (density),
      .random_bit (random_bit),
      .busy       (busy),
      .done       (done),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Sample value for cell k; bits are sent MSB first.
   function automatic logic [DB-1:0] pick(input int mode, input int k);
      case (mode)
         1:       return '0;
         2:       return '1;
         3:       return DB'(6);
         4:       return (k % 2 == 1) ? DB'(5) : DB'(2);
         default: return DB'($urandom_range(0, (1 << DB) - 1));
      endcase
   endfunction

   task automatic run_seed(input int dens, input int mode, input int stall_cell,
                           input int stall_len, input int poke_cell, input int rst_cell);
      logic [DB-1:0] s;
      logic [DB-1:0] dens_q;
      logic          exp_alive;
      int            ticks;
      int            extra;
      dens_q     = DB'(dens);
      extra      = 0;
      density    = dens_q;
      start      = 1'b1;
      random_bit = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      ticks = 0;
      chk("busy_after_start", busy, 1);
      chk("valid_after_start", wr_valid, 0);
      for (int k = 0; k < NCELL; k++) begin
         s         = pick(mode, k);
         exp_alive = (s < dens_q);
         for (int b = DB - 1; b >= 0; b--) begin
            random_bit = s[b];
            if (k == poke_cell && b == DB - 1) begin
               start   = 1'b1;
               density = '0;
            end
            tick();
            ticks++;
            start = 1'b0;
            if (b != 0) chk("valid_in_gather", wr_valid, 0);
         end
         random_bit = 1'($urandom_range(0, 1));
         chk("wr_valid", wr_valid, 1);
         chk("wr_addr", 32'(wr_addr), k);
         chk("wr_data", wr_data, exp_alive);
         if (k == rst_cell) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("rst_valid", wr_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_addr", 32'(wr_addr), 0);
            return;
         end
         if (k == stall_cell) begin
            wr_ready = 1'b0;
            for (int i = 0; i < stall_len; i++) begin
               random_bit = 1'($urandom_range(0, 1));
               tick();
               ticks++;
               extra++;
               chk("stall_valid", wr_valid, 1);
               chk("stall_addr", 32'(wr_addr), k);
               chk("stall_data", wr_data, exp_alive);
            end
            wr_ready = 1'b1;
         end
         tick();
         ticks++;
         if (k < NCELL - 1) begin
            chk("done_early", done, 0);
            chk("busy_mid", busy, 1);
         end
      end
      chk("done_pulse", done, 1);
      chk("busy_at_done", busy, 0);
      chk("valid_at_done", wr_valid, 0);
      chk("done_latency", ticks + 1, NCELL * (DB + 1) + 1 + extra);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("done_single", done, 0);
         chk("busy_idle", busy, 0);
         chk("valid_idle", wr_valid, 0);
      end
   endtask

   initial begin
      tick();
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_valid", wr_valid, 0);
      chk("reset_addr", 32'(wr_addr), 0);
      chk("reset_data", wr_data, 0);
      reset = 1'b0;
      tick();
      chk("idle_valid", wr_valid, 0);

      run_seed(4, 1, -1, 0, -1, -1);   // all samples 0 -> alive
      run_seed(0, 4, -1, 0, -1, -1);   // density 0 -> all dead
      run_seed(7, 2, -1, 0, -1, -1);   // sample 7 -> dead at max density
      run_seed(7, 3, -1, 0, -1, -1);   // sample 6 -> alive at max density
      run_seed(5, 0, 37, 10, -1, -1);  // stall at cell 37
      run_seed(6, 0, -1, 0, 100, -1);  // restart + density change at cell 100
      run_seed(3, 0, -1, 0, -1, 200);  // reset during write of cell 200
      tick();
      run_seed(2, 0, -1, 0, -1, -1);   // fresh run after reset

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conway_board_seeder.md
Name: conway_board_seeder

Overview:
- Consumes the serial random bit stream from the board's LFSR and writes a random initial pattern into the Conway board cell memory.
- Sits between the RNG and the board RAM write port. It is triggered by the "randomize" command from the terminal/control logic.
- Cell density is programmable. Each cell is decided from DENSITY_BITS consecutive random bits compared against a threshold.

Parameters:
- BOARD_WIDTH, 32, cells per row.
- BOARD_HEIGHT, 16, rows.
- DENSITY_BITS, 3, random bits consumed per cell. Also the width of the density threshold.
- Derived localparams, not overridable: CELLS = BOARD_WIDTH*BOARD_HEIGHT; ADDR_W = $clog2(CELLS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to reseed the board. Honoured only in IDLE.
- density  in  DENSITY_BITS  alive threshold. A cell is alive iff its sample < density. Latched on the accepted start.
- random_bit  in  1  serial bit from the LFSR. One new bit is assumed valid every clk.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last cell write completes.
- wr_valid  out  1  cell write request to board RAM.
- wr_ready  in  1  board RAM accepts the write when wr_valid && wr_ready.
- wr_addr  out  ADDR_W  linear cell index, row*BOARD_WIDTH+col.
- wr_data  out  1  cell state, 1 = alive.

Behaviour:
- Reset: FSM=IDLE; busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0; sample shift register, bit counter and cell counter cleared.
- FSM states: IDLE, GATHER, WRITE, FINISH.
- IDLE:
  - On start=1: latch density, clear cell counter and bit counter, go to GATHER.
  - Otherwise stay.
- GATHER:
  - Each cycle: sample <= {sample[DENSITY_BITS-2:0], random_bit}, so the first bit ends up as MSB; bit counter increments.
  - After exactly DENSITY_BITS cycles, go to WRITE.
  - On entering WRITE, register wr_data = (sample < latched density), unsigned compare, and wr_addr = cell counter.
  - random_bit is ignored outside GATHER.
- WRITE:
  - wr_valid=1. wr_addr and wr_data stay stable until the handshake.
  - On wr_valid && wr_ready: if cell counter == CELLS-1, go to FINISH. Otherwise increment the cell counter, clear the bit counter, go to GATHER.
  - wr_ready low stalls indefinitely with outputs held.
- FINISH: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- busy=1 in GATHER and WRITE only.
- start asserted while not in IDLE is ignored. No queuing.
- Changes to density while busy have no effect.
- Latency with wr_ready held high: DENSITY_BITS+1 cycles per cell. done asserts CELLS*(DENSITY_BITS+1)+1 cycles after the start cycle.
- Density boundaries: density=0 → all cells dead; density=2^DENSITY_BITS-1 → alive unless the sample is all ones.
- Cell counter must not wrap. The last address is CELLS-1 and no write is issued past it.
- Reset mid-operation: immediate return to IDLE with wr_valid deasserted the next cycle. Partially written board contents are left as-is.
- wr_valid never asserts outside WRITE.

Decomposition:
- Shared package conway_pkg holds:
  - BOARD_WIDTH/BOARD_HEIGHT defaults and the CELLS/ADDR_W derivation, shared with the life engine and the VGA renderer.
  - The seeder FSM state enum.
- One natural sub-module: seeder_sampler. It contains the DENSITY_BITS shift register, bit counter and threshold compare, exposing sample_done and alive.
- The FSM, cell counter and write handshake stay in the top module.

Test Plan:
- Reset then start, density=4, random_bit=0 constant, wr_ready=1 → 512 writes, addr 0..511 in order, all wr_data=1; done pulses at cycle 2049 after start; busy low after.
- density=0, random_bit toggling → all 512 writes have wr_data=0.
- density=7, random_bit=1 constant (sample=7) → all dead. Then rerun with the pattern 1,1,0 per cell (sample=6) → all alive.
- wr_ready held low for 10 cycles at cell 37 → wr_valid stays high, addr 37 and data stable; no extra random bits consumed; sequence resumes at cell 38.
- start pulsed again at cell 100 and density changed to 0 mid-run → ignored; remaining cells use the original threshold; single done pulse.
- reset asserted during WRITE at cell 200 → next cycle wr_valid=0, busy=0, IDLE. A new start then begins again from addr 0.
